cmp_result_tracker: RTL and testbench
=====================================

Name: cmp_result_tracker

Overview:
- Downstream consumer of the 4-bit magnitude comparator's registered G/L/E outputs.
- Classifies each cycle's comparator result and accumulates greater/less/equal/error counts over fixed windows of WIN enabled cycles.
- Publishes the counts at each window end with a one-cycle done strobe.
- Raises an equal-lock flag after LOCK_RUN consecutive equal results. Used by frequency-divider control to judge counter/reference match stability.

Parameters:
WIN, 16, samples per accumulation window (legal range 2..255)
CW, 8, width of each event counter; counters saturate at 2^CW-1
LOCK_RUN, 4, consecutive equal samples needed to set eq_lock (legal range 1..255)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-low
en  input  1  tracking enable; driven from the same select that enables the comparator
clr  input  1  synchronous clear of window, published counts and lock
g_in  input  4  comparator "greater" output
l_in  input  4  comparator "less" output
e_in  input  4  comparator "equal" output
gt_cnt  output  CW  published greater count of last completed window
lt_cnt  output  CW  published less count
eq_cnt  output  CW  published equal count
err_cnt  output  CW  published invalid-combination count
win_done  output  1  one-cycle pulse when published counts update
eq_lock  output  1  equal-lock status
busy  output  1  high while in RUN

Behaviour:
- Reset (rst=0 at a clock edge): all outputs 0, internal counters 0, window timer 0, run counter 0, state IDLE.
- Control priority: rst > clr > en.
- Sample classification (each input is "set" when nonzero):
  - exactly one of g_in/l_in/e_in set -> GT, LT or EQ
  - none set -> NONE
  - two or more set -> ERR
- State machine, two states:
  - IDLE: busy=0; sampled inputs are ignored; internal counters, timer and run counter are held at 0. en=1 -> RUN; the IDLE-cycle input is not counted (this absorbs the comparator's 1-cycle latency).
  - RUN: busy=1; every edge consumes one sample.
    - Timer increments on every sample, including NONE.
    - The matching internal counter increments (GT, LT, EQ, ERR); NONE increments no counter.
    - en=0 -> IDLE; partial window is discarded; published outputs and eq_lock keep their values except eq_lock clears (see below).
- Window end: on the edge that consumes the WIN-th sample (timer==WIN-1):
  - gt_cnt/lt_cnt/eq_cnt/err_cnt load the final counts, including that sample;
  - win_done=1 for exactly the following cycle;
  - internal counters and timer return to 0.
  - State stays RUN, so windows run back-to-back with no gap sample.
- Saturation: internal counters stop at 2^CW-1 and never wrap. The timer is independent of CW.
- eq_lock:
  - Run counter increments on each EQ sample in RUN and saturates at LOCK_RUN; any GT, LT, ERR or NONE sample resets it to 0.
  - eq_lock=1 from the edge where the run counter reaches LOCK_RUN.
  - eq_lock=0 on the edge of any non-EQ sample, on leaving RUN, on clr or on reset.
  - Independent of window boundaries; may coincide with win_done.
- clr=1:
  - internal counters, timer and run counter go to 0;
  - published counts go to 0; eq_lock=0; win_done=0.
  - Next state is RUN if en=1, else IDLE; clr-cycle input is not counted.
  - A clr on a window-end edge suppresses that publish.
- Reset mid-window: everything returns to reset values; no partial publish.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then en=1; 16 samples in RUN: 10×GT (g=1), 4×LT, 2×EQ -> win_done high one cycle after the 16th edge; gt=10, lt=4, eq=2, err=0; busy=1 throughout.
- Back-to-back windows: 32 samples of GT followed by EQ pattern (16 GT, then 16 EQ) -> two win_done pulses exactly 16 cycles apart; second publish gt=0, eq=16; eq_lock=1 after the 4th EQ edge.
- Error/NONE handling: one window of 8×(g=1,e=1), 4×all-zero, 4×LT -> err=8, lt=4, gt=0, eq=0; 4-EQ run interrupted by NONE after 3 -> eq_lock stays 0.
- Saturation with CW=4, WIN=20: 20×GT -> gt_cnt=15, not 4.
- en dropped after 7 samples, then restored for a full window of 16 EQ -> no win_done for the partial window; prior published values held; next publish eq=16.
- clr on the window-end edge (after 15 samples plus the 16th) -> no win_done, all counts 0, eq_lock 0. rst=0 mid-window -> all outputs 0 and busy=0 next cycle.

Source files
------------

// File: rtl/cmp_result_tracker_if.sv
// cmp_result_tracker_if
//   Bundles the comparator-result inputs and the published statistics of
//   cmp_result_tracker.
//   master : drives en, clr, g_in/l_in/e_in; observes the published results
//   slave  : the tracker itself
//   en/clr        tracking enable / synchronous clear
//   g_in/l_in/e_in  4-bit comparator greater/less/equal outputs
//   gt/lt/eq/err_cnt  published counts of the last completed window (CW bits)
//   win_done      one-cycle publish strobe
//   eq_lock       equal-lock status
//   busy          high while tracking (RUN)
interface cmp_result_tracker_if #(
   parameter int unsigned CW = 8
);
   logic          en;
   logic          clr;
   logic [3:0]    g_in;
   logic [3:0]    l_in;
   logic [3:0]    e_in;
   logic [CW-1:0] gt_cnt;
   logic [CW-1:0] lt_cnt;
   logic [CW-1:0] eq_cnt;
   logic [CW-1:0] err_cnt;
   logic          win_done;
   logic          eq_lock;
   logic          busy;

   modport master (
      output en, clr, g_in, l_in, e_in,
      input  gt_cnt, lt_cnt, eq_cnt, err_cnt, win_done, eq_lock, busy
   );

   modport slave (
      input  en, clr, g_in, l_in, e_in,
      output gt_cnt, lt_cnt, eq_cnt, err_cnt, win_done, eq_lock, busy
   );
endinterface

// File: rtl/cmp_result_tracker.sv
// cmp_result_tracker
//   Classifies each cycle's magnitude-comparator result (GT/LT/EQ/NONE/ERR),
//   accumulates GT/LT/EQ/ERR counts over back-to-back windows of WIN samples,
//   publishes them with a one-cycle win_done strobe, and raises eq_lock after
//   LOCK_RUN consecutive EQ samples.
//   clk  : clock, rising edge
//   rst  : synchronous, active-low reset
//   bus  : cmp_result_tracker_if slave (inputs en/clr/g_in/l_in/e_in,
//          registered outputs gt/lt/eq/err_cnt, win_done, eq_lock, busy)
module cmp_result_tracker #(
   parameter int unsigned WIN      = 16,
   parameter int unsigned CW       = 8,
   parameter int unsigned LOCK_RUN = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   cmp_result_tracker_if.slave  bus
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [7:0]    WIN_LAST = 8'(WIN - 1);
   localparam logic [7:0]    RUN_MAX  = 8'(LOCK_RUN);

   state_t        state_q;
   logic [7:0]    timer_q;
   logic [7:0]    run_q, run_d;
   logic [CW-1:0] gt_q, lt_q, eq_q, err_q;
   logic [CW-1:0] gt_d, lt_d, eq_d, err_d;
   logic [CW-1:0] gt_cnt_q, lt_cnt_q, eq_cnt_q, err_cnt_q;
   logic          win_done_q, eq_lock_q, busy_q;

   logic g_set, l_set, e_set;
   logic is_gt, is_lt, is_eq, is_err;

   // Sample classification: a line is "set" when any bit is nonzero.
   always_comb begin
      g_set  = |bus.g_in;
      l_set  = |bus.l_in;
      e_set  = |bus.e_in;
      is_gt  = g_set & ~l_set & ~e_set;
      is_lt  = l_set & ~g_set & ~e_set;
      is_eq  = e_set & ~g_set & ~l_set;
      is_err = (g_set & l_set) | (g_set & e_set) | (l_set & e_set);
   end

   // Saturating next counts for the sample consumed this edge.
   always_comb begin
      gt_d  = gt_q;
      lt_d  = lt_q;
      eq_d  = eq_q;
      err_d = err_q;
      if (is_gt  && gt_q  != CNT_MAX) gt_d  = gt_q  + 1'b1;
      if (is_lt  && lt_q  != CNT_MAX) lt_d  = lt_q  + 1'b1;
      if (is_eq  && eq_q  != CNT_MAX) eq_d  = eq_q  + 1'b1;
      if (is_err && err_q != CNT_MAX) err_d = err_q + 1'b1;
      run_d = '0;
      if (is_eq) run_d = (run_q == RUN_MAX) ? run_q : run_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         run_q      <= '0;
         gt_q       <= '0;
         lt_q       <= '0;
         eq_q       <= '0;
         err_q      <= '0;
         gt_cnt_q   <= '0;
         lt_cnt_q   <= '0;
         eq_cnt_q   <= '0;
         err_cnt_q  <= '0;
         win_done_q <= 1'b0;
         eq_lock_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else if (bus.clr) begin
         // Clear overrides a coincident window end, so nothing is published.
         state_q    <= bus.en ? RUN : IDLE;
         busy_q     <= bus.en;
         timer_q    <= '0;
         run_q      <= '0;
         gt_q       <= '0;
         lt_q       <= '0;
         eq_q       <= '0;
         err_q      <= '0;
         gt_cnt_q   <= '0;
         lt_cnt_q   <= '0;
         eq_cnt_q   <= '0;
         err_cnt_q  <= '0;
         win_done_q <= 1'b0;
         eq_lock_q  <= 1'b0;
      end else begin
         win_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // The IDLE-cycle sample is dropped to absorb comparator latency.
               timer_q <= '0;
               run_q   <= '0;
               gt_q    <= '0;
               lt_q    <= '0;
               eq_q    <= '0;
               err_q   <= '0;
               if (bus.en) begin
                  state_q <= RUN;
                  busy_q  <= 1'b1;
               end
            end
            RUN: begin
               if (!bus.en) begin
                  // Partial window discarded; published counts are kept.
                  state_q   <= IDLE;
                  busy_q    <= 1'b0;
                  timer_q   <= '0;
                  run_q     <= '0;
                  gt_q      <= '0;
                  lt_q      <= '0;
                  eq_q      <= '0;
                  err_q     <= '0;
                  eq_lock_q <= 1'b0;
               end else begin
                  run_q     <= run_d;
                  eq_lock_q <= (run_d == RUN_MAX);
                  if (timer_q == WIN_LAST) begin
                     gt_cnt_q   <= gt_d;
                     lt_cnt_q   <= lt_d;
                     eq_cnt_q   <= eq_d;
                     err_cnt_q  <= err_d;
                     win_done_q <= 1'b1;
                     timer_q    <= '0;
                     gt_q       <= '0;
                     lt_q       <= '0;
                     eq_q       <= '0;
                     err_q      <= '0;
                  end else begin
                     timer_q <= timer_q + 8'd1;
                     gt_q    <= gt_d;
                     lt_q    <= lt_d;
                     eq_q    <= eq_d;
                     err_q   <= err_d;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.gt_cnt   = gt_cnt_q;
   assign bus.lt_cnt   = lt_cnt_q;
   assign bus.eq_cnt   = eq_cnt_q;
   assign bus.err_cnt  = err_cnt_q;
   assign bus.win_done = win_done_q;
   assign bus.eq_lock  = eq_lock_q;
   assign bus.busy     = busy_q;

endmodule

// File: tb/tb_cmp_result_tracker.sv
// tb_cmp_result_tracker
//   Table-driven check of cmp_result_tracker (WIN=16, CW=8, LOCK_RUN=4) plus a
//   hand-written saturation/clear sequence on a second instance (WIN=20, CW=4).
module tb_cmp_result_tracker;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cmp_result_tracker_if #(.CW(8)) bus ();
   cmp_result_tracker_if #(.CW(4)) bus2 ();

   cmp_result_tracker #(.WIN(16), .CW(8), .LOCK_RUN(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   cmp_result_tracker #(.WIN(20), .CW(4), .LOCK_RUN(4)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   typedef struct {
      string       name;
      logic        rst;
      logic        en;
      logic        clr;
      logic [3:0]  g, l, e;
      int unsigned n;
      logic [7:0]  gt, lt, eq, err;
      logic        done, lock, busy;
   } vec_t;

   vec_t vecs[$];
   int   passed = 0;
   int   total  = 0;

   task automatic add(input string name, input logic r, input logic en, input logic clr,
                      input logic [3:0] g, input logic [3:0] l, input logic [3:0] e,
                      input int unsigned n,
                      input logic [7:0] gt, input logic [7:0] lt, input logic [7:0] eq,
                      input logic [7:0] err, input logic done, input logic lock,
                      input logic busy);
      vec_t v;
      v.name = name; v.rst = r; v.en = en; v.clr = clr;
      v.g = g; v.l = l; v.e = e; v.n = n;
      v.gt = gt; v.lt = lt; v.eq = eq; v.err = err;
      v.done = done; v.lock = lock; v.busy = busy;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got gt/lt/eq/err/done/lock/busy=%h/%h/%h/%h/%b/%b/%b required %h/%h/%h/%h/%b/%b/%b",
                    name, act[34:27], act[26:19], act[18:11], act[10:3], act[2], act[1], act[0],
                    exp[34:27], exp[26:19], exp[18:11], exp[10:3], exp[2], exp[1], exp[0]);
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %b required %b", name, act, exp);
   endtask

   localparam logic [3:0] Z = 4'h0;

   initial begin
      logic stray;
      logic [34:0] act, exp;

      bus.en = 1'b0; bus.clr = 1'b0; bus.g_in = Z; bus.l_in = Z; bus.e_in = Z;
      bus2.en = 1'b0; bus2.clr = 1'b0; bus2.g_in = Z; bus2.l_in = Z; bus2.e_in = Z;

      //   name          rst en clr g     l     e     n   gt  lt  eq  err dn lk by
      add("reset",        0, 0, 0, Z,    Z,    Z,    2,  0,  0,  0,  0, 0, 0, 0);
      add("idle_entry",   1, 1, 0, Z,    Z,    Z,    1,  0,  0,  0,  0, 0, 0, 1);
      add("w1_gt10",      1, 1, 0, 4'h1, Z,    Z,   10,  0,  0,  0,  0, 0, 0, 1);
      add("w1_lt4",       1, 1, 0, Z,    4'h2, Z,    4,  0,  0,  0,  0, 0, 0, 1);
      add("w1_eq1",       1, 1, 0, Z,    Z,    4'h8, 1,  0,  0,  0,  0, 0, 0, 1);
      add("w1_publish",   1, 1, 0, Z,    Z,    4'h8, 1, 10,  4,  2,  0, 1, 0, 1);
      add("w2_first",     1, 1, 0, 4'h1, Z,    Z,    1, 10,  4,  2,  0, 0, 0, 1);
      add("w2_publish",   1, 1, 0, 4'hF, Z,    Z,   15, 16,  0,  0,  0, 1, 0, 1);
      add("w3_eq3",       1, 1, 0, Z,    Z,    4'h3, 3, 16,  0,  0,  0, 0, 0, 1);
      add("w3_lock",      1, 1, 0, Z,    Z,    4'h8, 1, 16,  0,  0,  0, 0, 1, 1);
      add("w3_publish",   1, 1, 0, Z,    Z,    4'h1,12,  0,  0, 16,  0, 1, 1, 1);
      add("w4_err8",      1, 1, 0, 4'h1, Z,    4'h1, 8,  0,  0, 16,  0, 0, 0, 1);
      add("w4_none4",     1, 1, 0, Z,    Z,    Z,    4,  0,  0, 16,  0, 0, 0, 1);
      add("w4_publish",   1, 1, 0, Z,    4'h4, Z,    4,  0,  4,  0,  8, 1, 0, 1);
      add("run3_eq",      1, 1, 0, Z,    Z,    4'h8, 3,  0,  4,  0,  8, 0, 0, 1);
      add("run_none",     1, 1, 0, Z,    Z,    Z,    1,  0,  4,  0,  8, 0, 0, 1);
      add("run_eq1",      1, 1, 0, Z,    Z,    4'h8, 1,  0,  4,  0,  8, 0, 0, 1);
      add("partial7",     1, 1, 0, Z,    Z,    4'h8, 2,  0,  4,  0,  8, 0, 0, 1);
      add("en_drop",      1, 0, 0, Z,    Z,    4'h8, 1,  0,  4,  0,  8, 0, 0, 0);
      add("idle_hold",    1, 0, 0, 4'h1, Z,    Z,    2,  0,  4,  0,  8, 0, 0, 0);
      add("re_enable",    1, 1, 0, Z,    Z,    4'h8, 1,  0,  4,  0,  8, 0, 0, 1);
      add("eq16_publish", 1, 1, 0, Z,    Z,    4'h8,16,  0,  0, 16,  0, 1, 1, 1);
      add("pre_clr15",    1, 1, 0, Z,    Z,    4'h8,15,  0,  0, 16,  0, 0, 1, 1);
      add("clr_on_end",   1, 1, 1, Z,    Z,    4'h8, 1,  0,  0,  0,  0, 0, 0, 1);
      add("post_clr_win", 1, 1, 0, 4'h1, Z,    Z,   16, 16,  0,  0,  0, 1, 0, 1);
      add("mid_win5",     1, 1, 0, 4'h1, Z,    Z,    5, 16,  0,  0,  0, 0, 0, 1);
      add("rst_mid_win",  0, 1, 0, 4'h1, Z,    Z,    1,  0,  0,  0,  0, 0, 0, 0);
      add("rst_release",  1, 1, 0, 4'h1, Z,    Z,    1,  0,  0,  0,  0, 0, 0, 1);
      add("rst_fresh_win",1, 1, 0, 4'h1, Z,    Z,   16, 16,  0,  0,  0, 1, 0, 1);

      @(posedge clk); #1;
      foreach (vecs[i]) begin
         rst = vecs[i].rst; bus.en = vecs[i].en; bus.clr = vecs[i].clr;
         bus.g_in = vecs[i].g; bus.l_in = vecs[i].l; bus.e_in = vecs[i].e;
         stray = 1'b0;
         for (int unsigned k = 0; k < vecs[i].n; k++) begin
            @(posedge clk); #1;
            if (k + 1 < vecs[i].n && bus.win_done !== 1'b0) stray = 1'b1;
         end
         if (vecs[i].n > 1) check_bit({vecs[i].name, "_no_early_done"}, stray, 1'b0);
         act = {bus.gt_cnt, bus.lt_cnt, bus.eq_cnt, bus.err_cnt, bus.win_done, bus.eq_lock, bus.busy};
         exp = {vecs[i].gt, vecs[i].lt, vecs[i].eq, vecs[i].err, vecs[i].done, vecs[i].lock, vecs[i].busy};
         check(vecs[i].name, act, exp);
      end

      // Saturation on the CW=4, WIN=20 instance: 1 IDLE cycle + 20 GT samples.
      bus2.en = 1'b1; bus2.g_in = 4'h1;
      stray = 1'b0;
      for (int unsigned k = 0; k < 21; k++) begin
         @(posedge clk); #1;
         if (k < 20 && bus2.win_done !== 1'b0) stray = 1'b1;
      end
      check_bit("sat_no_early_done", stray, 1'b0);
      check_bit("sat_done", bus2.win_done, 1'b1);
      check("sat_gt15", {4'h0, bus2.gt_cnt, 4'h0, bus2.lt_cnt, 4'h0, bus2.eq_cnt, 4'h0, bus2.err_cnt,
                         bus2.win_done, bus2.eq_lock, bus2.busy},
                        {8'd15, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1});

      // Clear with en low: counts zero, returns to IDLE.
      bus2.clr = 1'b1; bus2.en = 1'b0;
      @(posedge clk); #1;
      bus2.clr = 1'b0;
      check("sat_clr_idle", {4'h0, bus2.gt_cnt, 4'h0, bus2.lt_cnt, 4'h0, bus2.eq_cnt, 4'h0, bus2.err_cnt,
                             bus2.win_done, bus2.eq_lock, bus2.busy},
                            {8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0});

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
